// File: rtl/branch_predict_tracker.sv
// Fetch/execute companion of the global-history predictor: issues predictions,
// queues them in order until resolve, drives renew, flushes on mispredict.
module branch_predict_tracker #(
    parameter int DEPTH     = 4,
    parameter int CNT_WIDTH = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       fetch_branch_valid,
    output logic                       fetch_ready,
    output logic                       predict_valid,
    input  logic                       predict_result,
    output logic                       fetch_pred_valid,
    output logic                       fetch_pred_taken,
    input  logic                       resolve_valid,
    input  logic                       resolve_taken,
    output logic                       renew_valid,
    output logic                       last_predict,
    output logic                       renew_result,
    output logic                       mispredict,
    output logic [$clog2(DEPTH):0]     outstanding,
    output logic                       underflow,
    output logic [CNT_WIDTH-1:0]       stat_resolved,
    output logic [CNT_WIDTH-1:0]       stat_mispredict
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = PTR_W + 1;

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    logic [DEPTH-1:0] queue_bits;
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic             pend;
    logic [OCC_W:0]   occ_sum;
    logic             head_bit;
    logic             do_resolve;
    logic             flush;
    logic             capture;
    logic             pop;

    // The in-flight prediction in pend must be counted so a full queue can never be overrun.
    assign occ_sum          = {1'b0, outstanding} + {{OCC_W{1'b0}}, pend};
    assign fetch_ready      = occ_sum < (OCC_W + 1)'(DEPTH);
    assign predict_valid    = fetch_branch_valid & fetch_ready;
    assign fetch_pred_valid = pend;
    assign fetch_pred_taken = predict_result;

    assign head_bit   = queue_bits[head];
    assign do_resolve = resolve_valid && (outstanding != '0);
    assign flush      = do_resolve && (head_bit != resolve_taken);
    assign capture    = pend && !flush;
    assign pop        = do_resolve && !flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend            <= 1'b0;
            head            <= '0;
            tail            <= '0;
            outstanding     <= '0;
            renew_valid     <= 1'b0;
            last_predict    <= 1'b0;
            renew_result    <= 1'b0;
            mispredict      <= 1'b0;
            underflow       <= 1'b0;
            stat_resolved   <= '0;
            stat_mispredict <= '0;
        end else begin
            pend <= predict_valid && !flush;
            if (flush) begin
                head        <= '0;
                tail        <= '0;
                outstanding <= '0;
            end else begin
                if (capture) tail <= tail + 1'b1;
                if (pop)     head <= head + 1'b1;
                case ({capture, pop})
                    2'b10:   outstanding <= outstanding + 1'b1;
                    2'b01:   outstanding <= outstanding - 1'b1;
                    default: outstanding <= outstanding;
                endcase
            end
            renew_valid  <= do_resolve;
            last_predict <= do_resolve & head_bit;
            renew_result <= do_resolve & resolve_taken;
            mispredict   <= flush;
            if (do_resolve) stat_resolved   <= sat_inc(stat_resolved);
            if (flush)      stat_mispredict <= sat_inc(stat_mispredict);
            if (resolve_valid && (outstanding == '0)) underflow <= 1'b1;
        end
    end

    // Queue payload carries no control meaning until counted, so it needs no reset.
    always_ff @(posedge clk) begin
        if (capture) queue_bits[tail] <= predict_result;
    end

endmodule

// File: tb/tb_branch_predict_tracker.sv
// Bench for branch_predict_tracker: directed scenarios plus random traffic against a queue model.
module tb_branch_predict_tracker;

    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic fetch_branch_valid = 1'b0;
    logic predict_result = 1'b0;
    logic resolve_valid = 1'b0;
    logic resolve_taken = 1'b0;

    logic fetch_ready, predict_valid, fetch_pred_valid, fetch_pred_taken;
    logic renew_valid, last_predict, renew_result, mispredict, underflow;
    logic [2:0]  outstanding;
    logic [15:0] stat_resolved, stat_mispredict;

    logic s_fetch_ready, s_predict_valid, s_fetch_pred_valid, s_fetch_pred_taken;
    logic s_renew_valid, s_last_predict, s_renew_result, s_mispredict, s_underflow;
    logic [2:0] s_outstanding;
    logic [1:0] s_stat_resolved, s_stat_mispredict;

    always #5 clk = ~clk;

    branch_predict_tracker #(.DEPTH(DEPTH), .CNT_WIDTH(16)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .fetch_branch_valid(fetch_branch_valid), .fetch_ready(fetch_ready),
        .predict_valid(predict_valid), .predict_result(predict_result),
        .fetch_pred_valid(fetch_pred_valid), .fetch_pred_taken(fetch_pred_taken),
        .resolve_valid(resolve_valid), .resolve_taken(resolve_taken),
        .renew_valid(renew_valid), .last_predict(last_predict),
        .renew_result(renew_result), .mispredict(mispredict),
        .outstanding(outstanding), .underflow(underflow),
        .stat_resolved(stat_resolved), .stat_mispredict(stat_mispredict)
    );

    branch_predict_tracker #(.DEPTH(DEPTH), .CNT_WIDTH(2)) u_sat (
        .clk(clk), .rst_n(rst_n),
        .fetch_branch_valid(fetch_branch_valid), .fetch_ready(s_fetch_ready),
        .predict_valid(s_predict_valid), .predict_result(predict_result),
        .fetch_pred_valid(s_fetch_pred_valid), .fetch_pred_taken(s_fetch_pred_taken),
        .resolve_valid(resolve_valid), .resolve_taken(resolve_taken),
        .renew_valid(s_renew_valid), .last_predict(s_last_predict),
        .renew_result(s_renew_result), .mispredict(s_mispredict),
        .outstanding(s_outstanding), .underflow(s_underflow),
        .stat_resolved(s_stat_resolved), .stat_mispredict(s_stat_mispredict)
    );

    int tests = 0;
    int fails = 0;
    int pv_pulses = 0;

    // Reference model: queue of pending predictions plus last retirement info.
    bit mq[$];
    bit m_pend, m_rv, m_lp, m_rr, m_mis, m_uf;
    int m_sr, m_sm;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int sat(input int v, input int maxv);
        return (v > maxv) ? maxv : v;
    endfunction

    task automatic model_reset();
        mq.delete();
        m_pend = 0; m_rv = 0; m_lp = 0; m_rr = 0; m_mis = 0; m_uf = 0;
        m_sr = 0; m_sm = 0;
    endtask

    task automatic model_update();
        bit fr, pv, flush, h;
        fr = (mq.size() + int'(m_pend)) < DEPTH;
        pv = fetch_branch_valid && fr;
        flush = 0;
        m_rv = 0; m_lp = 0; m_rr = 0; m_mis = 0;
        if (resolve_valid) begin
            if (mq.size() > 0) begin
                h = mq.pop_front();
                m_rv = 1; m_lp = h; m_rr = resolve_taken;
                m_mis = (h != resolve_taken);
                m_sr++;
                if (m_mis) m_sm++;
                flush = m_mis;
            end else begin
                m_uf = 1;
            end
        end
        if (flush) begin
            mq.delete();
            m_pend = 0;
        end else begin
            if (m_pend) mq.push_back(predict_result);
            m_pend = pv;
        end
    endtask

    task automatic check_all();
        bit fr;
        fr = (mq.size() + int'(m_pend)) < DEPTH;
        chk("fetch_ready", fetch_ready, fr);
        chk("predict_valid", predict_valid, fetch_branch_valid & fr);
        chk("fetch_pred_valid", fetch_pred_valid, m_pend);
        if (m_pend) chk("fetch_pred_taken", fetch_pred_taken, predict_result);
        chk("renew_valid", renew_valid, m_rv);
        chk("last_predict", last_predict, m_lp);
        chk("renew_result", renew_result, m_rr);
        chk("mispredict", mispredict, m_mis);
        chk("outstanding", outstanding, mq.size());
        chk("underflow", underflow, m_uf);
        chk("stat_resolved", stat_resolved, sat(m_sr, 65535));
        chk("stat_mispredict", stat_mispredict, sat(m_sm, 65535));
        chk("sat_stat_resolved", s_stat_resolved, sat(m_sr, 3));
        chk("sat_stat_mispredict", s_stat_mispredict, sat(m_sm, 3));
        if (predict_valid === 1'b1) pv_pulses++;
    endtask

    // One clock: drive inputs just after the edge, check at negedge, advance model at posedge.
    task automatic cyc(input bit fbv, input bit pr, input bit rv, input bit rt);
        fetch_branch_valid = fbv;
        predict_result     = pr;
        resolve_valid      = rv;
        resolve_taken      = rt;
        @(negedge clk);
        check_all();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic do_reset(input string tag);
        #3;
        rst_n = 1'b0;
        fetch_branch_valid = 0; predict_result = 0; resolve_valid = 0; resolve_taken = 0;
        #1;
        chk({tag, "_renew_valid"}, renew_valid, 0);
        chk({tag, "_last_predict"}, last_predict, 0);
        chk({tag, "_renew_result"}, renew_result, 0);
        chk({tag, "_mispredict"}, mispredict, 0);
        chk({tag, "_outstanding"}, outstanding, 0);
        chk({tag, "_underflow"}, underflow, 0);
        chk({tag, "_stat_resolved"}, stat_resolved, 0);
        chk({tag, "_stat_mispredict"}, stat_mispredict, 0);
        chk({tag, "_fetch_ready"}, fetch_ready, 1);
        chk({tag, "_fetch_pred_valid"}, fetch_pred_valid, 0);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        bit exp_h;
        model_reset();
        do_reset("rst_init");

        // Correct prediction, resolved three cycles after issue
        cyc(1, 0, 0, 0);
        cyc(0, 1, 0, 0);
        cyc(0, 0, 0, 0);
        cyc(0, 0, 1, 1);
        chk("correct_renew_valid", renew_valid, 1);
        chk("correct_last_predict", last_predict, 1);
        chk("correct_renew_result", renew_result, 1);
        chk("correct_mispredict", mispredict, 0);
        chk("correct_stat_resolved", stat_resolved, 1);
        cyc(0, 0, 0, 0);
        chk("correct_renew_drop", renew_valid, 0);

        // Fill to DEPTH with predictions 1,0,1,0 then drain in order
        do_reset("rst_full");
        pv_pulses = 0;
        cyc(1, 0, 0, 0);
        cyc(1, 1, 0, 0);
        cyc(1, 0, 0, 0);
        cyc(1, 1, 0, 0);
        cyc(1, 0, 0, 0);
        cyc(1, 0, 0, 0);
        chk("full_outstanding", outstanding, 4);
        chk("full_fetch_ready", fetch_ready, 0);
        chk("full_pv_pulses", pv_pulses, 4);
        cyc(0, 0, 1, 1);
        chk("full_ret0", last_predict, 1);
        cyc(0, 0, 1, 0);
        chk("full_ret1", last_predict, 0);
        cyc(0, 0, 1, 1);
        chk("full_ret2", last_predict, 1);
        cyc(0, 0, 1, 0);
        chk("full_ret3", last_predict, 0);
        chk("full_drained", outstanding, 0);
        chk("full_no_mis", stat_mispredict, 0);

        // Mispredict flush with queue [0,1,1] and one branch in pend
        do_reset("rst_flush");
        cyc(1, 0, 0, 0);
        cyc(1, 0, 0, 0);
        cyc(1, 1, 0, 0);
        cyc(1, 1, 0, 0);
        cyc(0, 1, 1, 1);
        chk("flush_mispredict", mispredict, 1);
        chk("flush_last_predict", last_predict, 0);
        chk("flush_renew_result", renew_result, 1);
        chk("flush_outstanding", outstanding, 0);
        chk("flush_stat_mis", stat_mispredict, 1);
        chk("flush_pend_clear", fetch_pred_valid, 0);
        cyc(0, 0, 1, 1);
        chk("flush_underflow", underflow, 1);
        chk("flush_uf_no_renew", renew_valid, 0);
        chk("flush_uf_stats", stat_resolved, 1);
        cyc(0, 0, 0, 0);
        chk("flush_uf_sticky", underflow, 1);

        // Concurrent capture and correct resolve
        do_reset("rst_conc");
        cyc(1, 0, 0, 0);
        cyc(1, 1, 0, 0);
        cyc(1, 0, 0, 0);
        cyc(0, 1, 1, 1);
        chk("conc_outstanding", outstanding, 2);
        cyc(0, 0, 1, 0);
        cyc(0, 0, 1, 1);
        chk("conc_third_ret", last_predict, 1);
        chk("conc_third_mis", mispredict, 0);

        // Counter saturation on the narrow instance
        do_reset("rst_sat");
        for (int i = 0; i < 5; i++) begin
            cyc(1, 0, 0, 0);
            cyc(0, 1, 0, 0);
            cyc(0, 0, 0, 0);
            cyc(0, 0, 1, 1);
        end
        chk("sat_resolved_w2", s_stat_resolved, 3);
        chk("sat_mispredict_w2", s_stat_mispredict, 0);
        chk("sat_resolved_w16", stat_resolved, 5);

        // Random traffic, with an asynchronous reset mid-stream
        do_reset("rst_rand");
        for (int i = 0; i < 400; i++) begin
            if (i == 200) do_reset("rst_mid");
            exp_h = (mq.size() > 0) ? mq[0] : 1'b0;
            cyc(1'($urandom % 2), 1'($urandom % 2), ($urandom % 3) == 0,
                (($urandom % 4) == 0) ? ~exp_h : exp_h);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
